// File: rtl/periph_resp_block_ot_pkg.sv
// Shared types for the peripheral interconnect response blocks: slave index,
// outstanding-count type and the control-state classification helper.
package periph_interco_pkg;

  localparam int N_SLAVE_DEF         = 16;
  localparam int MAX_OUTSTANDING_DEF = 4;

  // One extra bit so that the value N_SLAVE can act as the "unmapped" sentinel.
  typedef logic [$clog2(N_SLAVE_DEF):0]             slv_idx_t;
  typedef logic [$clog2(MAX_OUTSTANDING_DEF+1)-1:0] otcnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FULL,
    ST_ERR
  } ctrl_state_e;

  function automatic ctrl_state_e ctrl_state_f(input logic err_pend,
                                               input logic empty,
                                               input logic full);
    ctrl_state_e st;
    if (err_pend)   st = ST_ERR;
    else if (empty) st = ST_IDLE;
    else if (full)  st = ST_FULL;
    else            st = ST_BUSY;
    return st;
  endfunction

endpackage

// File: rtl/periph_resp_block_ot_addr_dec.sv
// Combinational PE address decoder: slave index from the routing field, or the
// N_SLAVE sentinel when the field is out of range or the address is out of cluster.
module periph_addr_dec_pe
  import periph_interco_pkg::*;
#(
  parameter int          N_SLAVE            = 16,
  parameter int          ADDR_WIDTH         = 32,
  parameter int          LOG_CLUSTER        = 5,
  parameter int          PE_ROUTING_LSB     = 16,
  parameter int          PE_ROUTING_MSB     = 19,
  parameter logic [11:0] CLUSTER_ALIAS_BASE = 12'h000,
  parameter int          IDX_W              = $clog2(N_SLAVE) + 1
) (
  input  logic [LOG_CLUSTER-1:0] cluster_id_i,
  input  logic [ADDR_WIDTH-1:0]  add_i,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   mapped_o
);

  localparam int FW = PE_ROUTING_MSB - PE_ROUTING_LSB + 1;

  logic [FW-1:0] tgt_field;
  logic [11:0]   region;
  logic [11:0]   cluster_base;
  logic          in_cluster;
  logic          unused_add;

  assign tgt_field    = add_i[PE_ROUTING_MSB:PE_ROUTING_LSB];
  assign region       = add_i[ADDR_WIDTH-1 -: 12];
  assign cluster_base = 12'h100 + 12'(cluster_id_i);
  assign in_cluster   = (region == CLUSTER_ALIAS_BASE) || (region == cluster_base);

  assign mapped_o = in_cluster && (32'(tgt_field) < N_SLAVE);
  assign idx_o    = mapped_o ? IDX_W'(tgt_field) : IDX_W'(N_SLAVE);

  // Only the region and routing bits matter; the offset bits are deliberately ignored.
  assign unused_add = ^add_i;

endmodule

// File: rtl/periph_resp_block_ot.sv
// Per-PE response block: decodes requests to N_SLAVE ports, tracks in-flight
// transactions and returns responses in issue order. Optional watchdog: PERIPH_RESP_TIMEOUT_EN.
module periph_resp_block_ot
  import periph_interco_pkg::*;
#(
  parameter int          ID                 = 1,
  parameter int          ID_WIDTH           = 17,
  parameter int          N_SLAVE            = 16,
  parameter int          DATA_WIDTH         = 32,
  parameter int          ADDR_WIDTH         = 32,
  parameter int          LOG_CLUSTER        = 5,
  parameter int          PE_ROUTING_LSB     = 16,
  parameter int          PE_ROUTING_MSB     = 19,
  parameter logic [11:0] CLUSTER_ALIAS_BASE = 12'h000,
  parameter int          MAX_OUTSTANDING    = 4,
  parameter int          TIMEOUT_CYCLES     = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [LOG_CLUSTER-1:0]          CLUSTER_ID,
  input  logic                            data_req_i,
  input  logic [ADDR_WIDTH-1:0]           data_add_i,
  output logic                            data_gnt_o,
  output logic [N_SLAVE-1:0]              data_req_o,
  input  logic [N_SLAVE-1:0]              data_gnt_i,
  output logic [ID_WIDTH-1:0]             data_ID_o,
  input  logic [N_SLAVE-1:0]              data_r_valid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0]   data_r_rdata_i,
  input  logic [N_SLAVE-1:0]              data_r_opc_i,
  output logic                            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]           data_r_rdata_o,
  output logic                            data_r_opc_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int              SW      = $clog2(N_SLAVE) + 1;
  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [SW-1:0]     tgt_idx, last_tgt_q, last_tgt_d;
  logic              tgt_mapped;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_pend_q, err_pend_d;
  ctrl_state_e       state;

  logic [N_SLAVE-1:0]    req_hit, rsp_sel;
  logic                  allow, gnt_int, accept;
  logic                  valid_mux, opc_mux;
  logic [DATA_WIDTH-1:0] rdata_mux;
  logic                  slv_rsp, to_rsp, rsp;

  periph_addr_dec_pe #(
    .N_SLAVE            (N_SLAVE),
    .ADDR_WIDTH         (ADDR_WIDTH),
    .LOG_CLUSTER        (LOG_CLUSTER),
    .PE_ROUTING_LSB     (PE_ROUTING_LSB),
    .PE_ROUTING_MSB     (PE_ROUTING_MSB),
    .CLUSTER_ALIAS_BASE (CLUSTER_ALIAS_BASE),
    .IDX_W              (SW)
  ) u_dec (
    .cluster_id_i (CLUSTER_ID),
    .add_i        (data_add_i),
    .idx_o        (tgt_idx),
    .mapped_o     (tgt_mapped)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVE; gi++) begin : g_sel
      assign req_hit[gi] = (tgt_idx == SW'(gi));
      assign rsp_sel[gi] = (last_tgt_q == SW'(gi));
    end
  endgenerate

  assign state = ctrl_state_f(err_pend_q, cnt_q == '0, cnt_q == CNT_MAX);

  // Switching targets only from IDLE keeps responses in issue order.
  assign allow = (state == ST_IDLE) || ((state == ST_BUSY) && (tgt_idx == last_tgt_q));

  assign gnt_int = tgt_mapped ? ((|(data_gnt_i & req_hit)) & allow)
                              : (data_req_i & (state == ST_IDLE));
  assign accept  = data_req_i & gnt_int;

  always_comb begin
    valid_mux = 1'b0;
    opc_mux   = 1'b0;
    rdata_mux = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (rsp_sel[i]) begin
        valid_mux = data_r_valid_i[i];
        opc_mux   = data_r_opc_i[i];
        rdata_mux = data_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign slv_rsp = valid_mux & (cnt_q != '0);
  assign rsp     = slv_rsp | err_pend_q | to_rsp;

`ifdef PERIPH_RESP_TIMEOUT_EN
  localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  // A real slave valid in the expiry cycle wins over the synthetic error.
  assign to_rsp  = (cnt_q != '0) && !slv_rsp && !err_pend_q && (timer_q == TIMER_LAST);
  assign timer_d = ((cnt_q == '0) || rsp) ? '0 : timer_q + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  logic unused_timeout_cfg;
  assign to_rsp             = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    cnt_d      = cnt_q;
    last_tgt_d = last_tgt_q;
    err_pend_d = 1'b0;
    if (accept) begin
      last_tgt_d = tgt_idx;
      err_pend_d = !tgt_mapped;
    end
    if (accept && !rsp)      cnt_d = cnt_q + CW'(1);
    else if (!accept && rsp) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      last_tgt_q <= '0;
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_tgt_q <= last_tgt_d;
      err_pend_q <= err_pend_d;
    end
  end

  // The request path is combinational, so every output is forced low while in reset.
  assign data_req_o     = rst_n ? ({N_SLAVE{data_req_i & allow & tgt_mapped}} & req_hit) : '0;
  assign data_gnt_o     = rst_n & gnt_int;
  assign data_ID_o      = rst_n ? (ID_WIDTH'(1) << ID) : '0;
  assign data_r_valid_o = rst_n & rsp;
  assign data_r_opc_o   = rst_n & (slv_rsp ? opc_mux : 1'b1) & rsp;
  assign data_r_rdata_o = (rst_n && slv_rsp) ? rdata_mux : '0;
  assign outstanding_o  = cnt_q;

endmodule
